// File: rtl/ds_interpolator.sv
// ds_interpolator: linear-interpolating upsampler feeding the delta-sigma modulator.
// Each input sample is followed by 2^LOG2_RATIO steps along a first-order ramp
// from the previous sample to the current one.
// Optional feature macro: DS_INTERP_UNDERRUN_COUNT_EN adds an 8-bit saturating
// underrun_count output.
module ds_interpolator #(
   parameter int WIDTH      = 16,
   parameter int LOG2_RATIO = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_sample,
   input  logic                    step,
   output logic signed [WIDTH-1:0] out_sample,
   output logic                    underrun
`ifdef DS_INTERP_UNDERRUN_COUNT_EN
   ,
   output logic [7:0]              underrun_count
`endif
);

   localparam int ACC_W   = WIDTH + LOG2_RATIO;
   localparam int DELTA_W = WIDTH + 1;

   logic signed [WIDTH-1:0]   prev_q, prev_d;
   logic signed [WIDTH-1:0]   curr_q, curr_d;
   logic signed [DELTA_W-1:0] delta_q, delta_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [LOG2_RATIO-1:0]     phase_q, phase_d;
   logic signed [WIDTH-1:0]   sample_buf_q, sample_buf_d;
   logic                      buf_valid_q, buf_valid_d;
   logic                      underrun_q, underrun_d;
   logic                      accept;
   logic                      wrap;

   assign in_ready   = !buf_valid_q && !reset;
   assign accept     = in_valid && in_ready;
   assign wrap       = step && (phase_q == '1);
   assign out_sample = acc_q[ACC_W-1:LOG2_RATIO];
   assign underrun   = underrun_q;

   // Next-state for the input buffer and the interpolation ramp.
   always_comb begin
      prev_d       = prev_q;
      curr_d       = curr_q;
      delta_d      = delta_q;
      acc_d        = acc_q;
      phase_d      = phase_q;
      sample_buf_d = sample_buf_q;
      buf_valid_d  = buf_valid_q;
      underrun_d   = underrun_q;

      if (accept) begin
         sample_buf_d = in_sample;
         buf_valid_d  = 1'b1;
      end

      if (step) begin
         if (wrap) begin
            acc_d   = $signed({curr_q, {LOG2_RATIO{1'b0}}});
            prev_d  = curr_q;
            phase_d = '0;
            if (buf_valid_q) begin
               curr_d      = sample_buf_q;
               delta_d     = DELTA_W'(sample_buf_q) - DELTA_W'(curr_q);
               buf_valid_d = 1'b0;
            end else begin
               delta_d    = '0;
               underrun_d = 1'b1;
            end
         end else begin
            acc_d   = acc_q + ACC_W'(delta_q);
            phase_d = phase_q + 1'b1;
         end
      end
   end

   // State registers with synchronous reset clearing everything at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q       <= '0;
         curr_q       <= '0;
         delta_q      <= '0;
         acc_q        <= '0;
         phase_q      <= '0;
         sample_buf_q <= '0;
         buf_valid_q  <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         prev_q       <= prev_d;
         curr_q       <= curr_d;
         delta_q      <= delta_d;
         acc_q        <= acc_d;
         phase_q      <= phase_d;
         sample_buf_q <= sample_buf_d;
         buf_valid_q  <= buf_valid_d;
         underrun_q   <= underrun_d;
      end
   end

`ifdef DS_INTERP_UNDERRUN_COUNT_EN
   logic [7:0] underrun_count_q, underrun_count_d;

   assign underrun_count = underrun_count_q;

   // Count starved wraps, saturating at the top of the 8-bit range.
   always_comb begin
      underrun_count_d = underrun_count_q;
      if (wrap && !buf_valid_q && (underrun_count_q != 8'hFF)) begin
         underrun_count_d = underrun_count_q + 8'd1;
      end
   end

   // Underrun counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         underrun_count_q <= '0;
      end else begin
         underrun_count_q <= underrun_count_d;
      end
   end
`endif

   // The ramp always stays between the two end-points it interpolates.
   a_out_between_endpoints : assert property (@(posedge clk) disable iff (reset)
      ((out_sample >= prev_q) && (out_sample <= curr_q)) ||
      ((out_sample <= prev_q) && (out_sample >= curr_q)));

endmodule
